// File: rtl/tpu_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tpu_seq_pkg : state encoding and phase-length helper for the tile sequencer
// Revision    : 1.0
// ----------------------------------------------------------------------------
package tpu_seq_pkg;

  localparam int unsigned SW = 3;

  localparam logic [SW-1:0] S_IDLE   = 3'd0;
  localparam logic [SW-1:0] S_LOAD_W = 3'd1;
  localparam logic [SW-1:0] S_CLEAR  = 3'd2;
  localparam logic [SW-1:0] S_STREAM = 3'd3;
  localparam logic [SW-1:0] S_FLUSH  = 3'd4;
  localparam logic [SW-1:0] S_DRAIN  = 3'd5;
  localparam logic [SW-1:0] S_DONE   = 3'd6;

  // Cycles for the last activation to skew through an n x n array.
  function automatic int unsigned flush_len(input int unsigned n);
    return 2 * n - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_phase_cnt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tpu_phase_cnt : loadable down-counter with terminal-count flag and hold
// Revision      : 1.0
// ----------------------------------------------------------------------------
module tpu_phase_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_hold,
  output logic [W-1:0] o_cnt_nxt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;

  // Saturates at zero so an idle counter never wraps.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load) begin
      w_cnt_nxt = i_load_val;
    end else if (!i_hold && (r_cnt != '0)) begin
      w_cnt_nxt = r_cnt - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_cnt_nxt = w_cnt_nxt;
  assign o_tc      = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/tpu_tile_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tpu_tile_sequencer : phase sequencer for one N x N systolic MAC tile.
// Optional stall input enabled by defining TPU_SEQ_STALL_EN.  Revision 1.0
// ----------------------------------------------------------------------------
module tpu_tile_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int N  = 4,
  parameter int KW = 8,
  parameter int RW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
`ifdef TPU_SEQ_STALL_EN
  input  logic          stall,
`endif
  output logic          busy,
  output logic          done,
  output logic          w_load,
  output logic [RW-1:0] w_row,
  output logic          acc_clr,
  output logic          a_valid,
  output logic [KW-1:0] k_idx,
  output logic          drain_valid,
  output logic [RW-1:0] drain_row
);

  localparam int CW = (KW > $clog2(2 * N)) ? KW : $clog2(2 * N);
  localparam logic [CW-1:0] C_N_M1     = CW'(N - 1);
  localparam logic [CW-1:0] C_FLUSH_M1 = CW'(flush_len(N) - 1);

  logic [SW-1:0] r_state;
  logic [SW-1:0] w_state_nxt;
  logic [KW-1:0] r_k;
  logic          w_k_lat;
  logic          w_cnt_load;
  logic [CW-1:0] w_cnt_load_val;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_k_m1;
  logic          w_tc;
  logic          w_stall;

  logic          r_busy, r_done, r_w_load, r_acc_clr, r_a_valid, r_drain_valid;
  logic [RW-1:0] r_w_row, r_drain_row;
  logic [KW-1:0] r_k_idx;

  logic          w_busy_n, w_done_n, w_w_load_n, w_acc_clr_n, w_a_valid_n, w_drain_valid_n;
  logic [RW-1:0] w_w_row_n, w_drain_row_n;
  logic [KW-1:0] w_k_idx_n;

`ifdef TPU_SEQ_STALL_EN
  assign w_stall = stall && (r_state != S_IDLE) && (r_state != S_DONE);
`else
  assign w_stall = 1'b0;
`endif

  assign w_k_m1 = CW'(r_k) - CW'(1);

  tpu_phase_cnt #(
    .W (CW)
  ) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_hold     (w_stall),
    .o_cnt_nxt  (w_cnt_nxt),
    .o_tc       (w_tc)
  );

  // Each phase loads its length minus one and leaves on terminal count.
  always_comb begin
    w_state_nxt    = r_state;
    w_k_lat        = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_k_lat = 1'b1;
          if (k_len == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt    = S_LOAD_W;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = C_N_M1;
          end
        end
      end
      S_LOAD_W: begin
        if (!w_stall && w_tc) begin
          w_state_nxt = S_CLEAR;
          w_cnt_load  = 1'b1;
        end
      end
      S_CLEAR: begin
        if (!w_stall) begin
          w_state_nxt    = S_STREAM;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = w_k_m1;
        end
      end
      S_STREAM: begin
        if (!w_stall && w_tc) begin
          w_state_nxt    = S_FLUSH;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = C_FLUSH_M1;
        end
      end
      S_FLUSH: begin
        if (!w_stall && w_tc) begin
          w_state_nxt    = S_DRAIN;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = C_N_M1;
        end
      end
      S_DRAIN: begin
        if (!w_stall && w_tc) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    w_busy_n        = (w_state_nxt != S_IDLE);
    w_done_n        = (w_state_nxt == S_DONE);
    w_w_load_n      = (w_state_nxt == S_LOAD_W) && !w_stall;
    w_acc_clr_n     = (w_state_nxt == S_CLEAR)  && !w_stall;
    w_a_valid_n     = (w_state_nxt == S_STREAM) && !w_stall;
    w_drain_valid_n = (w_state_nxt == S_DRAIN)  && !w_stall;
    w_w_row_n       = '0;
    w_k_idx_n       = '0;
    w_drain_row_n   = '0;
    if (w_state_nxt == S_LOAD_W) w_w_row_n     = RW'(C_N_M1 - w_cnt_nxt);
    if (w_state_nxt == S_STREAM) w_k_idx_n     = KW'(w_k_m1 - w_cnt_nxt);
    if (w_state_nxt == S_DRAIN)  w_drain_row_n = RW'(C_N_M1 - w_cnt_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_w_load      <= 1'b0;
      r_w_row       <= '0;
      r_acc_clr     <= 1'b0;
      r_a_valid     <= 1'b0;
      r_k_idx       <= '0;
      r_drain_valid <= 1'b0;
      r_drain_row   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      if (w_k_lat) r_k <= k_len;
      r_busy        <= w_busy_n;
      r_done        <= w_done_n;
      r_w_load      <= w_w_load_n;
      r_w_row       <= w_w_row_n;
      r_acc_clr     <= w_acc_clr_n;
      r_a_valid     <= w_a_valid_n;
      r_k_idx       <= w_k_idx_n;
      r_drain_valid <= w_drain_valid_n;
      r_drain_row   <= w_drain_row_n;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign w_load      = r_w_load;
  assign w_row       = r_w_row;
  assign acc_clr     = r_acc_clr;
  assign a_valid     = r_a_valid;
  assign k_idx       = r_k_idx;
  assign drain_valid = r_drain_valid;
  assign drain_row   = r_drain_row;

endmodule
`default_nettype wire

// File: tb/tb_tpu_tile_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tpu_tile_sequencer : table, directed and random checks of the sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_tpu_tile_sequencer;

  localparam int N      = 4;
  localparam int KW     = 8;
  localparam int RW     = 2;
  localparam int BUDGET = 400;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          busy, done, w_load, acc_clr, a_valid, drain_valid;
  logic [RW-1:0] w_row, drain_row;
  logic [KW-1:0] k_idx;

  always #5 clk = ~clk;

  tpu_tile_sequencer #(
    .N  (N),
    .KW (KW),
    .RW (RW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .k_len       (k_len),
`ifdef TPU_SEQ_STALL_EN
    .stall       (stall),
`endif
    .busy        (busy),
    .done        (done),
    .w_load      (w_load),
    .w_row       (w_row),
    .acc_clr     (acc_clr),
    .a_valid     (a_valid),
    .k_idx       (k_idx),
    .drain_valid (drain_valid),
    .drain_row   (drain_row)
  );

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          w_load;
    logic [RW-1:0] w_row;
    logic          acc_clr;
    logic          a_valid;
    logic [KW-1:0] k_idx;
    logic          drain_valid;
    logic [RW-1:0] drain_row;
  } out_t;

  typedef struct {
    out_t o;
    bit   act;
  } pos_t;

  typedef struct {
    int k;
    int k_after;
    int lat;
    int wl;
    int clr;
    int av;
    int dr;
  } vec_t;

  pos_t q[$];
  pos_t cur;
  int   checks   = 0;
  int   failures = 0;

  function automatic pos_t idle_pos();
    pos_t p;
    p.o   = '0;
    p.act = 1'b0;
    return p;
  endfunction

  function automatic pos_t active_pos();
    pos_t p;
    p.o      = '0;
    p.o.busy = 1'b1;
    p.act    = 1'b1;
    return p;
  endfunction

  // Expected per-cycle schedule of one tile run of depth k.
  function automatic void build_run(int k);
    pos_t p;
    if (k != 0) begin
      for (int i = 0; i < N; i++) begin
        p = active_pos(); p.o.w_load = 1'b1; p.o.w_row = RW'(i); q.push_back(p);
      end
      p = active_pos(); p.o.acc_clr = 1'b1; q.push_back(p);
      for (int i = 0; i < k; i++) begin
        p = active_pos(); p.o.a_valid = 1'b1; p.o.k_idx = KW'(i); q.push_back(p);
      end
      for (int i = 0; i < 2 * N - 2; i++) q.push_back(active_pos());
      for (int i = 0; i < N; i++) begin
        p = active_pos(); p.o.drain_valid = 1'b1; p.o.drain_row = RW'(i); q.push_back(p);
      end
    end
    p = idle_pos(); p.o.busy = 1'b1; p.o.done = 1'b1; q.push_back(p);
  endfunction

  function automatic void model_reset();
    cur = idle_pos();
    q.delete();
  endfunction

  function automatic void model_edge();
    if (rst) begin
      model_reset();
    end else if (!cur.o.busy) begin
      if (start) begin
        build_run(int'(k_len));
        cur = q.pop_front();
      end
    end else if (stall && cur.act) begin
      cur.o.w_load      = 1'b0;
      cur.o.acc_clr     = 1'b0;
      cur.o.a_valid     = 1'b0;
      cur.o.drain_valid = 1'b0;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = idle_pos();
    end
  endfunction

  function automatic void check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void check_outputs(string name);
    out_t a;
    a = {busy, done, w_load, w_row, acc_clr, a_valid, k_idx, drain_valid, drain_row};
    checks++;
    if (a !== cur.o) begin
      failures++;
      $display("FAIL %s @%0t: got busy=%b done=%b wl=%b row=%0d clr=%b av=%b kidx=%0d dv=%b drow=%0d expected busy=%b done=%b wl=%b row=%0d clr=%b av=%b kidx=%0d dv=%b drow=%0d",
               name, $time, a.busy, a.done, a.w_load, a.w_row, a.acc_clr, a.a_valid, a.k_idx,
               a.drain_valid, a.drain_row, cur.o.busy, cur.o.done, cur.o.w_load, cur.o.w_row,
               cur.o.acc_clr, cur.o.a_valid, cur.o.k_idx, cur.o.drain_valid, cur.o.drain_row);
    end
  endfunction

  task automatic cyc(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(name);
  endtask

  task automatic run_tile(input string name, input int k, input int k_after, input int e_lat,
                          input int e_wl, input int e_clr, input int e_av, input int e_dr);
    int wl = 0, clr = 0, av = 0, dr = 0, got = -1;
    start = 1'b1;
    k_len = KW'(k);
    for (int c = 1; c <= BUDGET; c++) begin
      cyc(name);
      if (c == 1) begin
        start = 1'b0;
        k_len = KW'(k_after);
      end
      wl  += int'(w_load);
      clr += int'(acc_clr);
      av  += int'(a_valid);
      dr  += int'(drain_valid);
      if (done) begin
        got = c;
        break;
      end
    end
    check_int({name, "_latency"}, got, e_lat);
    check_int({name, "_w_load"}, wl, e_wl);
    check_int({name, "_acc_clr"}, clr, e_clr);
    check_int({name, "_a_valid"}, av, e_av);
    check_int({name, "_drain"}, dr, e_dr);
    cyc({name, "_post"});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   d, first, second, found;
    int   sl, armed, got;

    vecs[0] = '{8,   8,   24,  4, 1, 8,   4};
    vecs[1] = '{0,   0,   1,   0, 0, 0,   0};
    vecs[2] = '{1,   1,   17,  4, 1, 1,   4};
    vecs[3] = '{255, 255, 271, 4, 1, 255, 4};
    vecs[4] = '{8,   2,   24,  4, 1, 8,   4};
    vecs[5] = '{2,   200, 18,  4, 1, 2,   4};

    model_reset();
    #2;
    check_outputs("reset");
    repeat (3) cyc("reset_hold");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_tile($sformatf("vec%0d", i), vecs[i].k, vecs[i].k_after, vecs[i].lat,
               vecs[i].wl, vecs[i].clr, vecs[i].av, vecs[i].dr);
    end

    // start pulses during STREAM and DONE must be dropped
    start = 1'b1;
    k_len = 8'd3;
    cyc("ign_t0");
    start = 1'b0;
    d = int'(done);
    for (int c = 0; c < 40; c++) begin
      start = cur.o.a_valid || cur.o.done;
      k_len = 8'd9;
      cyc("ign");
      d += int'(done);
    end
    start = 1'b0;
    check_int("ign_done_count", d, 1);

    // held start gives back-to-back runs with one idle cycle between
    start  = 1'b1;
    k_len  = 8'd2;
    first  = -1;
    second = -1;
    for (int c = 1; c <= 40; c++) begin
      cyc("b2b");
      if (done) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    start = 1'b0;
    check_int("b2b_first", first, 18);
    check_int("b2b_gap", second - first, 19);
    repeat (25) cyc("b2b_tail");

    // asynchronous reset in the middle of STREAM
    start = 1'b1;
    k_len = 8'd8;
    cyc("rs_t0");
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 30 && found == 0; c++) begin
      cyc("rs");
      if (cur.o.a_valid && cur.o.k_idx == 8'd3) found = 1;
    end
    check_int("rs_reach_k3", found, 1);
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs("rs_async");
    cyc("rs_hold");
    #2 rst = 1'b0;
    d = 0;
    for (int c = 0; c < 30; c++) begin
      cyc("rs_after");
      d += int'(done);
    end
    check_int("rs_no_done", d, 0);
    run_tile("rs_rerun", 8, 8, 24, 4, 1, 8, 4);

`ifdef TPU_SEQ_STALL_EN
    start = 1'b1;
    k_len = 8'd8;
    sl    = 0;
    armed = 1;
    got   = -1;
    for (int c = 1; c <= BUDGET; c++) begin
      cyc("st");
      if (c == 1) start = 1'b0;
      if (sl > 0) begin
        sl--;
        if (sl == 0) stall = 1'b0;
      end else if (armed != 0 && cur.o.a_valid && cur.o.k_idx == 8'd5) begin
        stall = 1'b1;
        sl    = 3;
        armed = 0;
      end
      if (done) begin
        got = c;
        break;
      end
    end
    check_int("stall_latency", got, 27);
    stall = 1'b0;
    cyc("st_post");
`else
    sl = 0; armed = 0; got = 0;
`endif

    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 3) == 0);
      k_len = ($urandom_range(0, 15) == 0) ? KW'($urandom_range(0, 255))
                                           : KW'($urandom_range(0, 10));
`ifdef TPU_SEQ_STALL_EN
      stall = ($urandom_range(0, 4) == 0);
`endif
      cyc("rand");
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1 model_reset();
        check_outputs("rand_rst");
        #1 rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
